// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for the multi-cycle datapath. Each instruction walks
// FETCH -> DECODE -> EXEC/BRANCH/JUMP -> (MEM) -> (WB) and the FSM drives the
// datapath muxes, register-file / PC write enables and a request/ready memory
// handshake. Stalled memory cycles are counted; too many of them, or an
// illegal opcode, park the machine in a sticky TRAP state until trap_clr.
//
// Parameters
//   TIMEOUT_CYCLES  stalled memory cycles before a fault (0 = never)
//   BYTE_OPS_EN     0 makes lb/sb illegal
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   opcode[5:0]                IR[31:26], stable after the FETCH handshake
//   mem_ready                  memory accepts/completes the current request
//   trap_clr                   leave TRAP and clear the fault flags
//   mem_req, mem_we, i_or_d, byte_op           memory port controls
//   ir_write, pc_write, pc_write_cond, branch_ne  IR / PC load controls
//   reg_write, reg_dst, mem_to_reg, link, move    register-file controls
//   alu_src_a, alu_src_b[1:0], alu_op[2:0]        ALU operand / op select
//   pc_source[1:0]             00 ALU, 01 ALUOut, 10 jump target
//   illegal_op, mem_fault      sticky fault flags
//   state[2:0]                 current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit BYTE_OPS_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       trap_clr,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       byte_op,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       link,
    output logic       move,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_SUBI  = 6'b000011;
    localparam logic [5:0] OP_ANDI  = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SB    = 6'b010001;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100111;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111001;
    localparam logic [5:0] OP_MOVE  = 6'b100000;

    localparam logic [1:0] ASB_RT  = 2'b00;
    localparam logic [1:0] ASB_4   = 2'b01;
    localparam logic [1:0] ASB_IMM = 2'b10;
    localparam logic [1:0] ASB_SH2 = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_FN  = 3'b111;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;

    // A zero-width counter is not legal, so a disabled timeout keeps one bit.
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int             CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    // Everything that is registered straight out to a port. ir_write and the
    // FETCH part of pc_write are not here: they follow mem_ready directly.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       byte_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       link;
        logic       move;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // ---------------- opcode classification ----------------
    function automatic logic is_byte(input logic [5:0] op);
        return BYTE_OPS_EN && (op == OP_LB || op == OP_SB);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (BYTE_OPS_EN && op == OP_LB);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (BYTE_OPS_EN && op == OP_SB);
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SUBI) ||
               (op == OP_ANDI)  || (op == OP_ORI)  || (op == OP_SLTI) ||
               (op == OP_MOVE);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] aop;
        case (op)
            OP_SUBI: aop = ALU_SUB;
            OP_ANDI: aop = ALU_AND;
            OP_ORI:  aop = ALU_OR;
            OP_SLTI: aop = ALU_SLT;
            default: aop = ALU_ADD;   // addi, move and address generation
        endcase
        return aop;
    endfunction

    // Control word for the state being entered.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = ASB_4;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCS_ALU;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                c.alu_src_b = ASB_SH2;
                c.alu_op    = ALU_ADD;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                if (op == OP_RTYPE) begin
                    c.alu_src_b = ASB_RT;
                    c.alu_op    = ALU_FN;
                end else begin
                    c.alu_src_b = ASB_IMM;
                    c.alu_op    = imm_alu_op(op);
                end
                c.move = (op == OP_MOVE);
            end
            S_MEM: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
                c.mem_we  = is_store(op);
                c.byte_op = is_byte(op);
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = (op == OP_RTYPE);
                c.mem_to_reg = is_load(op);
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ASB_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_OUT;
                c.branch_ne     = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
                c.reg_write = (op == OP_JAL);
                c.link      = (op == OP_JAL);
            end
            default: c = '0;          // TRAP
        endcase
        return c;
    endfunction

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              illegal_q, mem_fault_q;
    logic              set_illegal, set_fault, clr_flags;
    logic              handshake, stall, timeout_hit;

    // mem_ready only counts while a request is actually on the port; the
    // first FETCH cycle after reset has no request yet.
    assign handshake   = ctrl_q.mem_req & mem_ready;
    assign stall       = ctrl_q.mem_req & ~mem_ready;
    assign timeout_hit = TIMEOUT_EN && stall && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        clr_flags   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (handshake) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d   = S_TRAP;
                    set_fault = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_alu(opcode) || is_load(opcode) || is_store(opcode)) begin
                    state_d = S_EXEC;
                end else if (is_branch(opcode)) begin
                    state_d = S_BRANCH;
                end else if (is_jump(opcode)) begin
                    state_d = S_JUMP;
                end else begin
                    state_d     = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = (is_load(opcode) || is_store(opcode)) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (handshake) begin
                    state_d = is_load(opcode) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d   = S_TRAP;
                    set_fault = 1'b1;
                end
            end
            S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP: begin
                if (trap_clr) begin
                    state_d   = S_FETCH;
                    clr_flags = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered; opcode is already stable whenever EXEC or later is entered.
        ctrl_d = decode_ctrl(state_d, opcode);

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (TIMEOUT_EN && stall) begin
            wait_d = wait_q + CNT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            ctrl_q      <= '0;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            wait_q  <= wait_d;
            if (clr_flags) begin
                illegal_q   <= 1'b0;
                mem_fault_q <= 1'b0;
            end else begin
                if (set_illegal) illegal_q   <= 1'b1;
                if (set_fault)   mem_fault_q <= 1'b1;
            end
        end
    end

    // IR and PC load in the very cycle the fetch completes.
    logic fetch_done;
    assign fetch_done = (state_q == S_FETCH) & handshake;

    assign mem_req       = ctrl_q.mem_req;
    assign mem_we        = ctrl_q.mem_we;
    assign i_or_d        = ctrl_q.i_or_d;
    assign byte_op       = ctrl_q.byte_op;
    assign ir_write      = fetch_done;
    assign pc_write      = ctrl_q.pc_write | fetch_done;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign branch_ne     = ctrl_q.branch_ne;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign link          = ctrl_q.link;
    assign move          = ctrl_q.move;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign illegal_op    = illegal_q;
    assign mem_fault     = mem_fault_q;
    assign state         = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

- Multi-cycle successor to the single-cycle opcode decoder; sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath muxes, register-file and PC write enables, and a request/ready memory handshake with wait states.
- Generalised by a configurable memory timeout, optional byte operations, and a sticky trap state for illegal opcodes and memory faults.
- Sits between the instruction register, the datapath and the unified memory port.

## Interface
- TIMEOUT_CYCLES, 16: stalled memory cycles before a fault is raised; 0 disables the timeout.
- BYTE_OPS_EN, 1: when 0, lb/sb decode as illegal.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  IR[31:26]; stable from the cycle after the FETCH handshake
- mem_ready  input  1  memory accepts/completes the current request
- trap_clr  input  1  leaves TRAP and clears the fault flags
- mem_req, mem_we, i_or_d, byte_op  output  1 each  memory request, write, address select (0 = PC, 1 = ALUOut), byte access
- ir_write, pc_write, pc_write_cond, branch_ne  output  1 each  IR load, unconditional PC load, branch PC load, branch on not-equal
- reg_write, reg_dst, mem_to_reg, link, move  output  1 each  register-file controls; link writes PC to $31
- alu_src_a  output  1  0 = PC, 1 = rs
- alu_src_b  output  2  00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  3  000 AND, 001 OR, 100 SLT, 101 ADD, 110 SUB, 111 R-type (funct)
- pc_source  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op, mem_fault  output  1 each  sticky fault flags
- state  output  3  current state code, for debug

## Operation
- Opcode map:
  - 000000 R-type; 000010 addi; 000011 subi; 000100 andi; 000101 ori; 000111 slti
  - 001000 lw; 001001 lb; 010000 sw; 010001 sb
  - 100011 beq; 100111 bne; 111000 j; 111001 jal; 100000 move
  - Every other code is illegal.
- State codes: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRANCH 5, JUMP 6, TRAP 7.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=101. In the cycle where mem_ready=1: ir_write=1, pc_write=1, pc_source=00, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=101 (branch target into ALUOut).
  - ALU, move, load or store opcodes → EXEC
  - beq/bne → BRANCH
  - j/jal → JUMP
  - illegal → TRAP, illegal_op set
- EXEC: alu_src_a=1. R-type: alu_src_b=00, alu_op=111. All others: alu_src_b=10 with
  - alu_op 101 for addi, move, lw, lb, sw, sb
  - 110 for subi, 000 for andi, 001 for ori, 100 for slti
  - move asserts move=1 (rs + zero immediate).
  - Next state: loads/stores → MEM; otherwise → WB.
- MEM: mem_req=1, i_or_d=1; mem_we=1 for sw/sb; byte_op=1 for lb/sb. On mem_ready: loads → WB, stores → FETCH.
- WB: reg_write=1; reg_dst=1 for R-type only; mem_to_reg=1 for lw/lb. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_source=01, branch_ne=1 for bne. Next state FETCH.
- JUMP: pc_write=1, pc_source=10; jal also asserts reg_write=1 and link=1. Next state FETCH.
- TRAP: all control outputs 0; flags held. trap_clr=1 → FETCH with both flags cleared. Only rst_n or trap_clr leaves TRAP.
- Outputs not listed for a state are 0.

## Timing
- Reset:
  - State is FETCH and the wait counter is 0.
  - While rst_n=0, all outputs are forced to 0, including flags and state=0.
  - The first request is issued in the cycle after rst_n rises.
- Handshake:
  - mem_ready is sampled only while mem_req=1 and ignored otherwise.
  - mem_req stays high, with address selects held, until ready.
  - ir_write and pc_write in FETCH depend combinationally on mem_ready.
- Latency with zero-wait memory (cycles per instruction):
  - R-type, I-ALU, move: 4
  - lw/lb: 5
  - sw/sb: 4
  - beq/bne: 3
  - j/jal: 3
  - Each memory wait cycle adds 1.
- Wait counter (width clog2(TIMEOUT_CYCLES+1)):
  - Increments on each FETCH/MEM cycle with mem_ready=0.
  - Clears on any state change.
  - When it holds TIMEOUT_CYCLES-1 and mem_ready is still 0 at the edge: → TRAP, mem_fault set.
  - mem_ready in that final cycle wins; no fault is raised.
- Reset mid-instruction: async return to FETCH; any partial memory write is abandoned.

## Test plan
- add R-type (opcode 000000), ready tied 1 → states 0,1,2,4; EXEC alu_op=111, alu_src_b=00; WB reg_write=1, reg_dst=1; back in FETCH at cycle 5.
- lw (001000) with mem_ready low 3 cycles in MEM → MEM lasts 4 cycles, i_or_d=1, mem_we=0; WB mem_to_reg=1; 8 cycles total.
- sb (010001), BYTE_OPS_EN=1 → MEM mem_we=1, byte_op=1, then FETCH with no WB. With BYTE_OPS_EN=0 → TRAP after DECODE, illegal_op=1.
- bne (100111) → BRANCH asserts pc_write_cond=1, branch_ne=1, alu_op=110, pc_source=01; jal (111001) → JUMP asserts pc_write=1, pc_source=10, reg_write=1, link=1.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → TRAP after 4 cycles, mem_fault=1; hold 10 cycles with outputs 0; trap_clr pulse → FETCH, flags 0.
- Drop rst_n low in MEM during a store → mem_we falls immediately, state=0; after release FETCH mem_req=1 next cycle; opcode 111111 → illegal_op.
